// File: rtl/trap_peak_detector.sv
// Pulse peak detector behind the trapezoidal shaper: finds threshold crossings, tracks the
// maximum, and emits one (amplitude, timestamp, width) event per pulse. Optional pile-up
// rejection is compiled in with `define PEAK_PILEUP_REJECT_EN.
module trap_peak_detector #(
  parameter int DATA_W    = 16,
  parameter int TS_W      = 32,
  parameter int WID_W     = 8,
  parameter int HOLDOFF   = 8,
  parameter int MAX_WIDTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filt_data,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic                     out_ready,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic        [TS_W-1:0]   peak_time,
  output logic        [WID_W-1:0]  peak_width,
  output logic        [CNT_W-1:0]  drop_cnt,
  output logic        [CNT_W-1:0]  pileup_cnt,
  output logic                     busy
);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [WID_W-1:0] WID_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef PEAK_PILEUP_REJECT_EN
  localparam bit PILEUP_EN = 1'b1;
`else
  localparam bit PILEUP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ABOVE,
    ST_HOLDOFF
  } state_t;

  state_t                     state, state_d;
  logic        [TS_W-1:0]     ts;
  logic signed [DATA_W-1:0]   s_q, s_prev;
  logic        [TS_W-1:0]     ts_q;
  logic signed [DATA_W-1:0]   max_amp, max_amp_d;
  logic        [TS_W-1:0]     max_ts, max_ts_d;
  logic        [WID_W-1:0]    width, width_d;
  logic        [HOLD_W-1:0]   hold_cnt, hold_cnt_d;
  logic                       rise;
  logic                       pulse_end;
  logic                       reject;
  logic                       emit;

  // Input stage: every sample is paired with the timestamp of the cycle it arrived in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state is always assigned with <=, so every register samples
      // the pre-edge values regardless of statement order.
      ts     <= '0;
      s_q    <= '0;
      ts_q   <= '0;
      s_prev <= '0;
    end else begin
      ts     <= ts + 1'b1;
      s_q    <= filt_data;
      ts_q   <= ts;
      s_prev <= s_q;
    end
  end

  assign rise   = (s_q > threshold) && (s_prev <= threshold);
  assign reject = PILEUP_EN && (32'(width) > MAX_WIDTH);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    state_d    = state;
    max_amp_d  = max_amp;
    max_ts_d   = max_ts;
    width_d    = width;
    hold_cnt_d = hold_cnt;
    pulse_end  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rise) begin
          state_d   = ST_ABOVE;
          max_amp_d = s_q;
          max_ts_d  = ts_q;
          width_d   = WID_W'(1);
        end
      end
      ST_ABOVE: begin
        if (s_q > threshold) begin
          if (width != WID_MAX) width_d = width + 1'b1;
          // Strict compare keeps the earliest sample of a flat top.
          if (s_q > max_amp) begin
            max_amp_d = s_q;
            max_ts_d  = ts_q;
          end
        end else begin
          pulse_end = 1'b1;
          if (HOLDOFF == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_HOLDOFF;
            hold_cnt_d = HOLD_W'(HOLDOFF - 1);
          end
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt == '0) state_d = ST_IDLE;
        else                hold_cnt_d = hold_cnt - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign emit = pulse_end && !reject;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      max_amp  <= '0;
      max_ts   <= '0;
      width    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      max_amp  <= max_amp_d;
      max_ts   <= max_ts_d;
      width    <= width_d;
      hold_cnt <= hold_cnt_d;
    end
  end

  // Single-entry output register: a held event is never overwritten, a new one is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_valid <= 1'b0;
      peak_amp   <= '0;
      peak_time  <= '0;
      peak_width <= '0;
      drop_cnt   <= '0;
    end else begin
      if (emit) begin
        if (!peak_valid || out_ready) begin
          peak_valid <= 1'b1;
          peak_amp   <= max_amp;
          peak_time  <= max_ts;
          peak_width <= width;
        end else if (drop_cnt != CNT_MAX) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end else if (out_ready) begin
        peak_valid <= 1'b0;
      end
    end
  end

`ifdef PEAK_PILEUP_REJECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pileup_cnt <= '0;
    end else if (pulse_end && reject && (pileup_cnt != CNT_MAX)) begin
      pileup_cnt <= pileup_cnt + 1'b1;
    end
  end
`else
  assign pileup_cnt = '0;
`endif

endmodule

// File: tb/tb_trap_peak_detector.sv
// Scoreboard bench for trap_peak_detector: a sample-index reference model predicts events,
// a negedge monitor compares whatever the DUT presents on the output handshake.
`timescale 1ns/1ps
module tb_trap_peak_detector;

  localparam int DATA_W    = 16;
  localparam int TS_W      = 8;
  localparam int WID_W     = 5;
  localparam int HOLDOFF   = 4;
  localparam int MAX_WIDTH = 20;
  localparam int CNT_W     = 3;
  localparam int THR       = 100;
  localparam int WID_SAT   = (1 << WID_W) - 1;
  localparam int CNT_SAT   = (1 << CNT_W) - 1;
  localparam int TS_MOD    = 1 << TS_W;

`ifdef PEAK_PILEUP_REJECT_EN
  localparam bit PILEUP_EN = 1'b1;
`else
  localparam bit PILEUP_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic signed [DATA_W-1:0] filt_data = '0;
  logic signed [DATA_W-1:0] threshold = DATA_W'(THR);
  logic                     out_ready = 1'b0;
  logic                     peak_valid;
  logic signed [DATA_W-1:0] peak_amp;
  logic        [TS_W-1:0]   peak_time;
  logic        [WID_W-1:0]  peak_width;
  logic        [CNT_W-1:0]  drop_cnt;
  logic        [CNT_W-1:0]  pileup_cnt;
  logic                     busy;

  trap_peak_detector #(
    .DATA_W(DATA_W), .TS_W(TS_W), .WID_W(WID_W),
    .HOLDOFF(HOLDOFF), .MAX_WIDTH(MAX_WIDTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .filt_data(filt_data), .threshold(threshold),
    .out_ready(out_ready), .peak_valid(peak_valid), .peak_amp(peak_amp),
    .peak_time(peak_time), .peak_width(peak_width), .drop_cnt(drop_cnt),
    .pileup_cnt(pileup_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int amp;
    int tstamp;
    int width;
  } event_t;

  event_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model, phrased over sample indices: a pulse is a run of samples above THR
  // whose first sample follows one at or below THR and starts no earlier than
  // HOLDOFF+1 samples after the previous pulse's terminating sample.
  int m_prev, m_pend_v, m_pend_t, m_idx, m_last_end, m_ts;
  int m_max, m_max_t, m_w, m_drop, m_pile;
  bit m_in, m_occ, m_busy;

  task automatic model_reset(input int held_sample);
    m_prev     = 0;
    m_pend_v   = held_sample;
    m_pend_t   = 0;
    m_idx      = 0;
    m_last_end = -1000;
    m_ts       = 0;
    m_in       = 1'b0;
    m_occ      = 1'b0;
    m_busy     = 1'b0;
    m_drop     = 0;
    m_pile     = 0;
    m_w        = 0;
    m_max      = 0;
    m_max_t    = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus; the model then accounts for the sample driven one step earlier.
  task automatic step(input int v, input bit rdy);
    bit     emit;
    event_t ev;
    @(posedge clk);
    m_ts = (m_ts + 1) % TS_MOD;
    #1;
    check("peak_valid", peak_valid, m_occ);
    check("busy", busy, m_busy);
    check("drop_cnt", drop_cnt, m_drop);
    check("pileup_cnt", pileup_cnt, m_pile);
    filt_data = DATA_W'(v);
    out_ready = rdy;

    emit = 1'b0;
    if (m_in) begin
      if (m_pend_v > THR) begin
        if (m_w < WID_SAT) m_w++;
        if (m_pend_v > m_max) begin
          m_max   = m_pend_v;
          m_max_t = m_pend_t;
        end
      end else begin
        m_in       = 1'b0;
        m_last_end = m_idx;
        if (PILEUP_EN && m_w > MAX_WIDTH) begin
          if (m_pile < CNT_SAT) m_pile++;
        end else begin
          emit = 1'b1;
        end
      end
    end else if (m_idx >= m_last_end + 1 + HOLDOFF && m_pend_v > THR && m_prev <= THR) begin
      m_in    = 1'b1;
      m_max   = m_pend_v;
      m_max_t = m_pend_t;
      m_w     = 1;
    end
    m_busy = m_in || (m_idx <= m_last_end + HOLDOFF - 1);

    if (emit) begin
      if (!m_occ || rdy) begin
        ev.amp    = m_max;
        ev.tstamp = m_max_t;
        ev.width  = m_w;
        exp_q.push_back(ev);
        m_occ = 1'b1;
      end else if (m_drop < CNT_SAT) begin
        m_drop++;
      end
    end else if (rdy) begin
      m_occ = 1'b0;
    end

    m_prev   = m_pend_v;
    m_pend_v = v;
    m_pend_t = m_ts;
    m_idx++;
  endtask

  task automatic do_reset(input int held_sample);
    #2;
    reset = 1'b0;
    #1;
    check("rst_peak_valid", peak_valid, 0);
    check("rst_peak_amp", peak_amp, 0);
    check("rst_peak_time", peak_time, 0);
    check("rst_peak_width", peak_width, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_pileup_cnt", pileup_cnt, 0);
    check("rst_busy", busy, 0);
    filt_data = DATA_W'(held_sample);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset(held_sample);
  endtask

  // Monitor: compares the presented event every cycle it is valid, retires it on acceptance.
  int n_accepted = 0;
  int last_amp, last_time, last_width;

  initial begin
    forever begin
      @(negedge clk);
      if (reset && peak_valid) begin
        check("event_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("peak_amp", peak_amp, exp_q[0].amp);
          check("peak_time", peak_time, exp_q[0].tstamp);
          check("peak_width", peak_width, exp_q[0].width);
          if (out_ready) begin
            last_amp   = int'(peak_amp);
            last_time  = int'(peak_time);
            last_width = int'(peak_width);
            n_accepted++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  int g_rem = 0;
  int g_height = 0;

  task automatic run_random(input int n, input int ready_pct);
    int v;
    for (int i = 0; i < n; i++) begin
      if (g_rem > 0) begin
        v = g_height + $urandom_range(0, 2);
        g_rem--;
      end else if ($urandom_range(0, 7) == 0) begin
        g_rem    = $urandom_range(1, 28);
        g_height = $urandom_range(101, 2000);
        v        = g_height;
      end else begin
        v = $urandom_range(0, 400) - 300;
      end
      step(v, $urandom_range(0, 99) < ready_pct);
    end
  endtask

  int base;
  int t_first;

  initial begin
    // Reset mid-pulse: the partial pulse must vanish; the falling tail must not trigger.
    do_reset(0);
    step(0, 1); step(300, 1); step(300, 1);
    base = n_accepted;
    do_reset(0);
    step(80, 1); step(50, 1);
    repeat (10) step(0, 1);
    check("t1_no_event", n_accepted - base, 0);

    // Reference pulse with the 150 sample tagged ts=12.
    do_reset(0);
    base = n_accepted;
    repeat (10) step(0, 1);
    step(50, 1); step(150, 1); step(300, 1); step(300, 1); step(300, 1);
    step(150, 1); step(50, 1); step(0, 1);
    repeat (8) step(0, 1);
    check("t2_count", n_accepted - base, 1);
    check("t2_amp", last_amp, 300);
    check("t2_time", last_time, 13);
    check("t2_width", last_width, 5);

    // Backpressure: first event held, second dropped.
    step(0, 0); step(150, 0); step(300, 0); step(150, 0); step(0, 0);
    repeat (10) step(0, 0);
    step(200, 0); step(400, 0); step(200, 0); step(0, 0);
    repeat (5) step(0, 0);
    @(negedge clk);
    check("t3_drop", drop_cnt, 1);
    check("t3_held_valid", peak_valid, 1);
    check("t3_held_amp", peak_amp, 300);
    base = n_accepted;
    repeat (4) step(0, 1);
    @(negedge clk);
    check("t3_released", peak_valid, 0);
    check("t3_accepted", n_accepted - base, 1);

    // Holdoff: a crossing 2 samples after the end is ignored, one 10 samples after is not.
    base = n_accepted;
    step(0, 1); step(200, 1); step(0, 1);
    step(0, 1); step(220, 1); step(0, 1);
    repeat (6) step(0, 1);
    step(250, 1); step(0, 1);
    repeat (8) step(0, 1);
    check("t4_count", n_accepted - base, 2);
    check("t4_amp", last_amp, 250);

    // Long pulse: pile-up when rejection is enabled, else reported in full.
    base = n_accepted;
    step(0, 1);
    step(500, 1);
    t_first = m_ts;
    repeat (24) step(500, 1);
    repeat (10) step(0, 1);
    if (PILEUP_EN) begin
      check("t5_no_event", n_accepted - base, 0);
      check("t5_pileup", pileup_cnt, 1);
    end else begin
      check("t5_count", n_accepted - base, 1);
      check("t5_amp", last_amp, 500);
      check("t5_width", last_width, 25);
      check("t5_time", last_time, t_first);
    end

    // Level already high out of reset triggers once, against the reset value of s_prev.
    do_reset(500);
    base = n_accepted;
    repeat (9) step(500, 1);
    step(-200, 1);
    repeat (10) step(-200, 1);
    check("t6_count", n_accepted - base, 1);
    check("t6_time", last_time, 0);
    check("t6_width", last_width, 10);

    // Timestamp wrap across the maximum.
    while (m_ts != TS_MOD - 3) step(0, 1);
    step(200, 1); step(300, 1); step(400, 1); step(350, 1); step(0, 1);
    repeat (6) step(0, 1);
    check("wrap_amp", last_amp, 400);
    check("wrap_time", last_time, 0);
    check("wrap_width", last_width, 4);

    // Randomised traffic with light and heavy backpressure and an async reset in between.
    run_random(800, 50);
    do_reset(0);
    g_rem = 0;
    run_random(700, 70);
    run_random(800, 10);
    repeat (40) step(0, 1);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
